// File: rtl/pll_cen_pkg.sv
// pll_cen_pkg: shared FSM encoding, synchroniser depth and channel-index width helper
package pll_cen_pkg;

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] HOLD      = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;

    localparam int SYNC_STAGES = 2;

    function automatic int CH_W(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_cen_acc.sv
// pll_cen_acc: one fractional clock-enable channel (num/den accumulator with glitch-free reload)
module pll_cen_acc #(
    parameter int               ACC_W   = 16,
    parameter logic [ACC_W-1:0] DEF_NUM = ACC_W'(1),
    parameter logic [ACC_W-1:0] DEF_DEN = ACC_W'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             clr,
    input  logic             apply,
    input  logic [ACC_W-1:0] new_num,
    input  logic [ACC_W-1:0] new_den,
    output logic             cen,
    output logic             wrap,
    output logic             nz
);

    logic [ACC_W-1:0] num, den, acc, acc_nxt;
    logic [ACC_W:0]   s;

    // one extra bit so acc+num never overflows before the compare
    assign s       = {1'b0, acc} + {1'b0, num};
    assign wrap    = s >= {1'b0, den};
    assign nz      = num == '0;
    assign acc_nxt = wrap ? ACC_W'(s - {1'b0, den}) : s[ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num <= DEF_NUM;
            den <= DEF_DEN;
            acc <= '0;
            cen <= 1'b0;
        end else begin
            cen <= active & wrap;
            if (apply | clr)
                acc <= '0;
            else if (active)
                acc <= acc_nxt;
            if (apply) begin
                num <= new_num;
                den <= new_den;
            end
        end
    end

endmodule

// File: rtl/pll_cen_gen.sv
// pll_cen_gen: lock-aware multi-channel fractional clock-enable generator with
// reset sequencing and a single-slot runtime ratio reconfiguration port.
module pll_cen_gen import pll_cen_pkg::*; #(
    parameter int                      NUM_CH    = 3,
    parameter int                      ACC_W     = 16,
    parameter int                      LOCK_HOLD = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] DEF_NUM   = {NUM_CH{ACC_W'(1)}},
    parameter logic [NUM_CH*ACC_W-1:0] DEF_DEN   = {NUM_CH{ACC_W'(1)}}
) (
    input  logic                      refclk,
    input  logic                      rst,
    input  logic                      locked_in,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [CH_W(NUM_CH)-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]          cfg_num,
    input  logic [ACC_W-1:0]          cfg_den,
    output logic                      cfg_err,
    output logic [NUM_CH-1:0]         cen,
    output logic                      sys_reset,
    output logic                      running
);

    localparam int CW = CH_W(NUM_CH);
    localparam int HW = $clog2(LOCK_HOLD + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   locked_s;
    logic [1:0]             state, nxt;
    logic [HW-1:0]          cnt;
    logic                   pend;
    logic [CW-1:0]          p_ch;
    logic [ACC_W-1:0]       p_num, p_den;
    logic [NUM_CH-1:0]      wrap, nz, app;
    logic                   xfer, bad, active, clr;

    assign locked_s = sync[SYNC_STAGES-1];

    always_comb begin
        nxt = !locked_s                                    ? WAIT_LOCK :
              state == WAIT_LOCK                           ? HOLD      :
              state == HOLD && cnt == HW'(LOCK_HOLD - 1)   ? RUN       : state;
    end

    // gating on locked_s too makes cen drop on the same edge the FSM leaves RUN
    assign active = state == RUN && locked_s;
    assign clr    = nxt == WAIT_LOCK && state != WAIT_LOCK;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync      <= '0;
            state     <= WAIT_LOCK;
            cnt       <= '0;
            sys_reset <= 1'b1;
            running   <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], locked_in};
            state     <= nxt;
            cnt       <= state == HOLD ? cnt + 1'b1 : '0;
            sys_reset <= nxt != RUN;
            running   <= nxt == RUN;
        end
    end

    assign cfg_ready = !pend;
    assign xfer      = cfg_valid & cfg_ready;
    assign bad       = 32'(cfg_ch) >= NUM_CH || cfg_den == '0 || cfg_num > cfg_den;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pend    <= 1'b0;
            p_ch    <= '0;
            p_num   <= '0;
            p_den   <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= xfer & bad;
            if (xfer & !bad) begin
                pend  <= 1'b1;
                p_ch  <= cfg_ch;
                p_num <= cfg_num;
                p_den <= cfg_den;
            end else if (|app) begin
                pend <= 1'b0;
            end
        end
    end

    // reload only at a wrap (or when idle) so the old ratio finishes its pulse cleanly
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign app[i] = pend && 32'(p_ch) == i && (state != RUN || nz[i] || wrap[i]);
        pll_cen_acc #(
            .ACC_W   (ACC_W),
            .DEF_NUM (DEF_NUM[i*ACC_W +: ACC_W]),
            .DEF_DEN (DEF_DEN[i*ACC_W +: ACC_W])
        ) u_acc (
            .clk     (refclk),
            .rst     (rst),
            .active  (active),
            .clr     (clr),
            .apply   (app[i]),
            .new_num (p_num),
            .new_den (p_den),
            .cen     (cen[i]),
            .wrap    (wrap[i]),
            .nz      (nz[i])
        );
    end

endmodule

// File: tb/tb_pll_cen_gen.sv
// tb_pll_cen_gen: scoreboard bench for lock sequencing, ratios, reconfiguration and resets
module tb_pll_cen_gen;

    logic        refclk, rst, locked_in, cfg_valid, cfg_ready, cfg_err, sys_reset, running;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_num, cfg_den;
    logic [2:0]  cen;

    int vectors = 0, miscompares = 0;
    string sb_tag[$];
    int    sb_val[$];

    pll_cen_gen #(.NUM_CH(3), .ACC_W(16), .LOCK_HOLD(16)) dut (
        .refclk(refclk), .rst(rst), .locked_in(locked_in),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_num(cfg_num), .cfg_den(cfg_den), .cfg_err(cfg_err),
        .cen(cen), .sys_reset(sys_reset), .running(running)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int v);
        sb_tag.push_back(tag);
        sb_val.push_back(v);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        if (sb_val.size() == 0)
            chk("sb_underflow", 1, 0);
        else
            chk(sb_tag.pop_front(), got, sb_val.pop_front());
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic send_cfg(input int ch, input int n, input int d);
        int k = 0;
        while (!cfg_ready && k < 300) begin
            step();
            k++;
        end
        chk("cfg_ready_timeout", k < 300, 1);
        cfg_ch    = 2'(ch);
        cfg_num   = 16'(n);
        cfg_den   = 16'(d);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic measure(input int c, input int n, output int pulses, output int gmin, output int gmax);
        int last = -1;
        pulses = 0;
        gmin   = 1 << 30;
        gmax   = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (cen[c]) begin
                if (last >= 0) begin
                    if (i - last < gmin) gmin = i - last;
                    if (i - last > gmax) gmax = i - last;
                end
                last = i;
                pulses++;
            end
        end
    endtask

    task automatic lock_seq(input string tag);
        int nc = 0;
        locked_in = 1'b1;
        for (int e = 0; e <= 18; e++) begin
            step();
            if (cen != 3'b000) nc++;
            if (e == 17) chk({tag, "_sysrst_e17"}, sys_reset, 1);
        end
        chk({tag, "_sysrst_e18"}, sys_reset, 0);
        chk({tag, "_running_e18"}, running, 1);
        chk({tag, "_nocen_pre19"}, nc, 0);
    endtask

    initial begin
        int p, gmin, gmax, bad, last, ph, pmin, pmax;
        int rc[3] = '{3, 0, 0};
        int rn[3] = '{1, 1, 5};
        int rd[3] = '{2, 0, 4};
        rst = 1'b1; locked_in = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_num = '0; cfg_den = '0;
        repeat (3) step();
        chk("rst_sys_reset", sys_reset, 1);
        chk("rst_running", running, 0);
        chk("rst_cen", cen, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_cfg_err", cfg_err, 0);
        rst = 1'b0;

        bad = 0;
        repeat (40) begin
            step();
            if (!sys_reset || running) bad++;
        end
        chk("nolock_stays_reset", bad, 0);

        lock_seq("lock");
        step();
        chk("lock_cen_e19", cen, 3'b111);
        measure(0, 20, p, gmin, gmax);
        chk("def_1_1_pulses", p, 20);

        sb_push("ch2_pulses", 60); sb_push("ch2_gap_min", 16); sb_push("ch2_gap_max", 17);
        send_cfg(2, 6, 100);
        step();
        measure(2, 1000, p, gmin, gmax);
        sb_pop(p); sb_pop(gmin); sb_pop(gmax);

        sb_push("num0_pulses", 0);
        send_cfg(1, 0, 5);
        step();
        measure(1, 500, p, gmin, gmax);
        sb_pop(p);

        sb_push("max_pulses", 100);
        send_cfg(0, 65535, 65535);
        step();
        measure(0, 100, p, gmin, gmax);
        sb_pop(p);

        sb_push("q_pulses", 10); sb_push("q_gap_min", 4); sb_push("q_gap_max", 4);
        send_cfg(0, 1, 4);
        step();
        measure(0, 40, p, gmin, gmax);
        sb_pop(p); sb_pop(gmin); sb_pop(gmax);

        // switch ch0 1/4 -> 1/2 mid-run, tracking the handover pulse
        last = -1; ph = 0; bad = 0; gmin = 99; gmax = 0; pmin = 99; pmax = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 9) begin
                cfg_ch = 2'd0; cfg_num = 16'd1; cfg_den = 16'd2; cfg_valid = 1'b1;
            end
            step();
            if (i == 9) cfg_valid = 1'b0;
            if (cen[0]) begin
                if (last >= 0) begin
                    if (i - last < gmin) gmin = i - last;
                    if (i - last > gmax) gmax = i - last;
                    if (ph == 3 && i - last < pmin) pmin = i - last;
                    if (ph == 3 && i - last > pmax) pmax = i - last;
                end
                last = i;
            end
            if (ph == 2) begin
                if (cen[0]) begin
                    chk("sw_ready_at_pulse", cfg_ready, 1);
                    ph = 3;
                end else if (cfg_ready) bad++;
            end
            if (i == 9) begin
                chk("sw_ready_low", cfg_ready, 0);
                ph = 2;
            end
        end
        chk("sw_applied", ph, 3);
        chk("sw_ready_early", bad, 0);
        chk("sw_gap_min", gmin, 2);
        chk("sw_gap_max", gmax, 4);
        chk("sw_post_gap_min", pmin, 2);
        chk("sw_post_gap_max", pmax, 2);

        for (int k = 0; k < 3; k++) begin
            sb_push("rej_err", 1); sb_push("rej_ready", 1); sb_push("rej_err_clr", 0);
            cfg_ch = 2'(rc[k]); cfg_num = 16'(rn[k]); cfg_den = 16'(rd[k]); cfg_valid = 1'b1;
            step();
            cfg_valid = 1'b0;
            sb_pop(cfg_err); sb_pop(cfg_ready);
            step();
            sb_pop(cfg_err);
        end
        sb_push("rej_keep_pulses", 10); sb_push("rej_keep_gmin", 2); sb_push("rej_keep_gmax", 2);
        measure(0, 20, p, gmin, gmax);
        sb_pop(p); sb_pop(gmin); sb_pop(gmax);

        locked_in = 1'b0;
        repeat (3) step();
        chk("loss_cen", cen, 0);
        chk("loss_sys_reset", sys_reset, 1);
        chk("loss_running", running, 0);
        repeat (5) step();
        lock_seq("relock");
        step();
        chk("relock_cen_e19", cen, 3'b000);
        step();
        chk("relock_cen_e20", cen, 3'b001);

        send_cfg(2, 0, 7);
        chk("pend_ready_low", cfg_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_sys_reset", sys_reset, 1);
        chk("arst_running", running, 0);
        chk("arst_cen", cen, 0);
        chk("arst_cfg_ready", cfg_ready, 1);
        chk("arst_cfg_err", cfg_err, 0);
        step();
        step();
        rst = 1'b0;
        lock_seq("postrst");
        step();
        chk("postrst_def_cen", cen, 3'b111);

        chk("sb_drain", sb_val.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_cen_gen.md
Name: pll_cen_gen

Overview:
- Parametrised, lock-aware clock-enable generator that runs on a single fast PLL output clock.
- Produces NUM_CH independent fractional clock-enable pulse trains, replacing extra PLL outputs for slow domains (e.g. 6 MHz from 100 MHz).
- Sequences a system reset from the PLL locked signal.
- Supports glitch-free runtime reprogramming of each channel's ratio through a valid/ready config port.

Parameters:
NUM_CH, 3, number of clock-enable channels (1..16)
ACC_W, 16, width of per-channel numerator/denominator/accumulator
LOCK_HOLD, 1024, refclk cycles locked must stay high before run (>=1)
DEF_NUM, {NUM_CH{16'd1}}, packed per-channel reset numerator (ch0 in LSBs)
DEF_DEN, {NUM_CH{16'd1}}, packed per-channel reset denominator

Ports:
refclk  in  1  the single clock (fast PLL output)
rst  in  1  asynchronous, active-high reset
locked_in  in  1  PLL locked, asynchronous to refclk
cfg_valid  in  1  config request
cfg_ready  out  1  config slot free
cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
cfg_num  in  ACC_W  new numerator
cfg_den  in  ACC_W  new denominator
cfg_err  out  1  one-cycle pulse: request rejected
cen  out  NUM_CH  registered clock-enable pulses
sys_reset  out  1  registered downstream reset, high until RUN
running  out  1  state==RUN

Behaviour:
- Reset values:
  - sys_reset=1, running=0, cen=0, cfg_ready=1, cfg_err=0.
  - Accumulators=0, num/den=DEF_NUM/DEF_DEN, state=WAIT_LOCK, pending=0.
- locked_in passes through a 2-FF synchroniser to give locked_s.
- FSM transitions:
  - WAIT_LOCK -> HOLD when locked_s=1; hold counter cleared.
  - HOLD increments the counter each cycle.
  - HOLD -> RUN on the edge where counter==LOCK_HOLD-1.
  - HOLD or RUN -> WAIT_LOCK whenever locked_s=0.
  - Counter and all accumulators clear on entry to WAIT_LOCK.
- sys_reset and running are registered from the next-state value.
  - Edge 0 is the first edge sampling locked_in=1.
  - sys_reset falls after edge LOCK_HOLD+2.
- Accumulator per channel, active only in RUN:
  - s = acc + num, computed ACC_W+1 bits wide.
  - If s >= den: acc <= s - den and cen[ch] <= 1; else acc <= s and cen[ch] <= 0.
  - Outside RUN, cen=0.
  - num==den gives cen every cycle; num==0 gives no pulses.
  - Long-run pulse rate is exactly num/den of refclk; pulse spacing is floor or ceil of den/num.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready.
  - Reject with a cfg_err pulse on the next cycle and no state change if cfg_ch>=NUM_CH, cfg_den==0 or cfg_num>cfg_den.
  - A valid request loads a single pending slot (ch, num, den); cfg_ready = !pending.
- Apply pending:
  - Applies on the edge where state!=RUN, or the target num==0, or the target channel wraps (s>=den).
  - On that edge: num/den <= pending values, acc <= 0, pending <= 0.
  - The cen for that edge uses the old values, so there are no runt or double pulses.
  - Earliest sequence: accept at edge T, pending set, apply at T+1, cfg_ready high after T+1.
- Asynchronous rst mid-operation returns everything to reset values immediately. Any pending config is lost, and num/den revert to DEF values.
- A locked drop does not reset num/den or pending; pending applies on the next edge (state!=RUN).

Decomposition:
- Shared package pll_cen_pkg holds:
  - FSM state encoding (WAIT_LOCK, HOLD, RUN).
  - The 2-stage synchroniser depth constant.
  - Helper function CH_W(n) = max(1,$clog2(n)).
- Sub-module pll_cen_acc: one channel with its num/den/acc registers, wrap compare, cen register and apply input. It is instantiated NUM_CH times in a generate loop.
- Top level holds the synchroniser, FSM, hold counter and config slot.

Test Plan:
- Lock timing: LOCK_HOLD=16, locked_in rises -> sys_reset falls after edge 18; running=1; no cen before edge 19; with locked_in=0, sys_reset stays 1 indefinitely.
- Ratio accuracy: ch2 num=6, den=100 -> exactly 60 cen pulses in 1000 RUN cycles; every gap is 16 or 17 cycles.
- Extremes: num=den=1 -> cen every cycle; num=0 -> no pulses for 500 cycles; num=den=65535 -> cen every cycle, no overflow.
- Reconfiguration: ch0 1/4 -> 1/2 mid-run -> cfg_ready low until the next ch0 pulse; gaps are 4 before and 2 after; no gap <2 or >4 at the switch.
- Rejects: cfg_ch=3 with NUM_CH=3, den=0, or num=5/den=4 -> cfg_err high one cycle; cfg_ready stays 1; cen pattern unchanged.
- Lock loss and reset: locked_in drops during RUN -> cen all 0 and sys_reset=1 within 3 edges; relock repeats the full LOCK_HOLD wait. Async rst mid-RUN -> outputs at reset values before the next edge; pending config discarded.
